// File: rtl/axil_io_bridge_if.sv
// axil_io_bridge_if: AXI4-Lite slave-side bundle (AW, W, B, AR, R) for the IO bridge.
interface axil_io_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_io_bridge.sv
// axil_io_bridge: terminates AXI4-Lite and issues one single-cycle IO bus access per
// transaction. Addresses outside the decoded window get DECERR and never reach the IO bus.
//
// state      | meaning
// IDLE       | AW/W/AR offered; prio picks the winner when read and write collide
// WR_COLLECT | one of AW/W latched, waiting for the other
// WR_ACCESS  | io_write_en is high this cycle (hit only)
// WR_RESP    | bvalid held until bready
// RD_ACCESS  | io_read_en is high this cycle (hit only)
// RD_WAIT    | peripheral drives io_read_data; captured at end of cycle
// RD_RESP    | rvalid held until rready
module axil_io_bridge #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'hFFFF0000,
    parameter int                    WINDOW_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    axil_io_bridge_if.slave       s,
    output logic                  io_write_en,
    output logic                  io_read_en,
    output logic [ADDR_WIDTH-1:0] io_address,
    output logic [DATA_WIDTH-1:0] io_write_data,
    input  logic [DATA_WIDTH-1:0] io_read_data
);

    typedef enum logic [2:0] {
        IDLE, WR_COLLECT, WR_ACCESS, WR_RESP, RD_ACCESS, RD_WAIT, RD_RESP
    } state_t;

    state_t                state;
    logic                  prio;       // 0: write wins a collision, 1: read wins
    logic                  idle_rdy;   // registered "ready to accept" in IDLE
    logic                  need_aw;
    logic                  need_w;
    logic                  hit_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  wr_req, wr_win, rd_win;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  launch_wr, wr_hit, rd_hit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  unused_wstrb;

    // Readies come from registered flags; the only same-cycle term is the
    // read/write arbitration, which must see the competing valid to pick one.
    assign wr_req    = s.awvalid | s.wvalid;
    assign wr_win    = ~(prio & s.arvalid);
    assign rd_win    = ~(~prio & wr_req);
    assign s.awready = (idle_rdy & wr_win) | need_aw;
    assign s.wready  = (idle_rdy & wr_win) | need_w;
    assign s.arready = idle_rdy & rd_win;

    assign aw_hs = s.awvalid & s.awready;
    assign w_hs  = s.wvalid & s.wready;
    assign ar_hs = s.arvalid & s.arready;

    // Address/data of the write being launched: fresh from the bus or from the latch.
    assign wr_addr   = aw_hs ? s.awaddr : addr_q;
    assign wr_data   = w_hs ? s.wdata : data_q;
    assign wr_hit    = wr_addr[ADDR_WIDTH-1:WINDOW_BITS] == BASE_ADDR[ADDR_WIDTH-1:WINDOW_BITS];
    assign rd_hit    = s.araddr[ADDR_WIDTH-1:WINDOW_BITS] == BASE_ADDR[ADDR_WIDTH-1:WINDOW_BITS];
    assign launch_wr = ((state == IDLE) & aw_hs & w_hs) |
                       ((state == WR_COLLECT) & (aw_hs | w_hs));

    assign s.bvalid = bvalid_q;
    assign s.bresp  = bresp_q;
    assign s.rvalid = rvalid_q;
    assign s.rresp  = rresp_q;
    assign s.rdata  = rdata_q;

    // Only full-word writes exist on the IO bus, so byte strobes carry no information.
    assign unused_wstrb = ^s.wstrb;

    // Transaction FSM; IO strobes are registered on the accepting edge so they
    // appear exactly in the ACCESS state and are zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            prio          <= 1'b0;
            idle_rdy      <= 1'b0;
            need_aw       <= 1'b0;
            need_w        <= 1'b0;
            hit_q         <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
            rvalid_q      <= 1'b0;
            rresp_q       <= 2'b00;
            rdata_q       <= '0;
            io_write_en   <= 1'b0;
            io_read_en    <= 1'b0;
            io_address    <= '0;
            io_write_data <= '0;
        end else begin
            io_write_en   <= 1'b0;
            io_read_en    <= 1'b0;
            io_address    <= '0;
            io_write_data <= '0;
            case (state)
                IDLE: begin
                    idle_rdy <= 1'b1;
                    if (aw_hs | w_hs) begin
                        idle_rdy <= 1'b0;
                        addr_q   <= wr_addr;
                        data_q   <= wr_data;
                        need_aw  <= ~aw_hs;
                        need_w   <= ~w_hs;
                        state    <= (aw_hs & w_hs) ? WR_ACCESS : WR_COLLECT;
                    end else if (ar_hs) begin
                        idle_rdy   <= 1'b0;
                        hit_q      <= rd_hit;
                        io_read_en <= rd_hit;
                        io_address <= rd_hit ? s.araddr : '0;
                        state      <= RD_ACCESS;
                    end
                end
                WR_COLLECT: begin
                    if (aw_hs | w_hs) begin
                        addr_q  <= wr_addr;
                        data_q  <= wr_data;
                        need_aw <= 1'b0;
                        need_w  <= 1'b0;
                        state   <= WR_ACCESS;
                    end
                end
                WR_ACCESS: begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= hit_q ? 2'b00 : 2'b11;
                    state    <= WR_RESP;
                end
                WR_RESP: begin
                    if (s.bready) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= 2'b00;
                        idle_rdy <= 1'b1;
                        if (s.arvalid) begin
                            prio <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                RD_ACCESS: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    rdata_q  <= hit_q ? io_read_data : '0;
                    rresp_q  <= hit_q ? 2'b00 : 2'b11;
                    rvalid_q <= 1'b1;
                    state    <= RD_RESP;
                end
                RD_RESP: begin
                    if (s.rready) begin
                        rvalid_q <= 1'b0;
                        rresp_q  <= 2'b00;
                        rdata_q  <= '0;
                        prio     <= 1'b0;
                        idle_rdy <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (launch_wr) begin
                hit_q       <= wr_hit;
                io_write_en <= wr_hit;
                if (wr_hit) begin
                    io_address    <= wr_addr;
                    io_write_data <= wr_data;
                end
            end
        end
    end

endmodule
